ipm2l_hsstlp_apb_arbiter_v1_0: RTL and testbench

//  Shares the single HSST fabric config APB master port (p_cfg_*) between NUM_REQ requesters
//  (e.g. PCIe rate-change sequencer, DRP user port). Round-robin arbitration, one 8-bit

---
 rtl/ipm2l_hsstlp_apb_pkg.sv | 19 +
 rtl/ipm2l_hsstlp_apb_rr_arb.sv | 34 +++
 rtl/ipm2l_hsstlp_apb_arbiter_v1_0.sv | 160 ++++++++++++++++
 tb/tb_ipm2l_hsstlp_apb_arbiter_v1_0.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ipm2l_hsstlp_apb_pkg.sv
// rtl/ipm2l_hsstlp_apb_pkg.sv - shared FSM encoding and HSST target decode constants
package ipm2l_hsstlp_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // addr[15:12] selects the HSST block behind the bridge
  localparam logic [3:0] TGT_CH0  = 4'h0;
  localparam logic [3:0] TGT_CH1  = 4'h1;
  localparam logic [3:0] TGT_CH2  = 4'h2;
  localparam logic [3:0] TGT_CH3  = 4'h3;
  localparam logic [3:0] TGT_PLL0 = 4'h4;
  localparam logic [3:0] TGT_PLL1 = 4'h5;

endpackage

// File: rtl/ipm2l_hsstlp_apb_rr_arb.sv
// rtl/ipm2l_hsstlp_apb_rr_arb.sv - combinational round-robin grant from a rotating start pointer
module ipm2l_hsstlp_apb_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  int            k;
  logic [IW-1:0] kk;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    kk      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = IW'(k);
      if (!valid_o && req_i[kk]) begin
        valid_o   = 1'b1;
        grant_o[kk] = 1'b1;
        idx_o     = kk;
      end
    end
  end

endmodule

// File: rtl/ipm2l_hsstlp_apb_arbiter_v1_0.sv
// rtl/ipm2l_hsstlp_apb_arbiter_v1_0.sv - round-robin sharing of the HSST config APB port
// Optional ACCESS-phase timeout enabled by defining HSST_APB_TIMEOUT_EN.
module ipm2l_hsstlp_apb_arbiter_v1_0
  import ipm2l_hsstlp_apb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  p_cfg_clk,
  input  logic                  p_cfg_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [16*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  p_cfg_psel,
  output logic                  p_cfg_enable,
  output logic                  p_cfg_write,
  output logic [15:0]           p_cfg_addr,
  output logic [7:0]            p_cfg_wdata,
  input  logic                  p_cfg_ready,
  input  logic [7:0]            p_cfg_rdata
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("ipm2l_hsstlp_apb_arbiter_v1_0: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  apb_state_e         state_q;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] owner_q, req_ready_q, rsp_valid_q;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0]      grant_idx;
  logic               grant_vld;
  logic               busy_q, psel_q, enable_q, write_q;
  logic [15:0]        addr_q, sel_addr;
  logic [7:0]         wdata_q, sel_wdata, rdata_q;
  logic               sel_write;

  ipm2l_hsstlp_apb_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .valid_o (grant_vld)
  );

  assign ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // One-hot mux keeps the requester buses out of variable-index selects
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr  = sel_addr  | (req_addr[16*i +: 16] & {16{grant_oh[i]}});
      sel_wdata = sel_wdata | (req_wdata[8*i +: 8]  & {8{grant_oh[i]}});
      sel_write = sel_write | (req_write[i] & grant_oh[i]);
    end
  end

`ifdef HSST_APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge p_cfg_clk) begin
    if (p_cfg_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      psel_q      <= 1'b0;
      enable_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef HSST_APB_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            req_ready_q <= grant_oh;
            owner_q     <= grant_oh;
            write_q     <= sel_write;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b1;
            psel_q      <= 1'b1;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          enable_q <= 1'b1;
          state_q  <= ST_ACCESS;
`ifdef HSST_APB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          if (p_cfg_ready) begin
            psel_q      <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= owner_q;
            rdata_q     <= write_q ? 8'h00 : p_cfg_rdata;
            state_q     <= ST_RESP;
`ifdef HSST_APB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (to_cnt_q == CNT_LAST) begin
            psel_q      <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= owner_q;
            rdata_q     <= 8'h00;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            to_cnt_q    <= to_cnt_q + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign busy         = busy_q;
  assign p_cfg_psel   = psel_q;
  assign p_cfg_enable = enable_q;
  assign p_cfg_write  = write_q;
  assign p_cfg_addr   = addr_q;
  assign p_cfg_wdata  = wdata_q;

endmodule

// File: tb/tb_ipm2l_hsstlp_apb_arbiter_v1_0.sv
// tb/tb_ipm2l_hsstlp_apb_arbiter_v1_0.sv - randomized self-checking bench with a transaction-level RR model
module tb_ipm2l_hsstlp_apb_arbiter_v1_0;

  localparam int N  = 3;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [16*N-1:0]   req_addr;
  logic [8*N-1:0]    req_wdata;
  logic [7:0]        rsp_rdata, wdata, p_cfg_rdata;
  logic              rsp_err, busy, psel, enable, write, p_cfg_ready;
  logic [15:0]       addr;

  int                n_chk = 0;
  int                n_err = 0;
  int                mptr  = 0;
  int                bridge_wait = 0;
  bit                bridge_never = 1'b0;
  logic [7:0]        bridge_rdata = 8'h00;
  int                acc_cnt = 0;

  ipm2l_hsstlp_apb_arbiter_v1_0 #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .p_cfg_clk    (clk),
    .p_cfg_rst    (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .p_cfg_psel   (psel),
    .p_cfg_enable (enable),
    .p_cfg_write  (write),
    .p_cfg_addr   (addr),
    .p_cfg_wdata  (wdata),
    .p_cfg_ready  (p_cfg_ready),
    .p_cfg_rdata  (p_cfg_rdata)
  );

  always #5 clk = ~clk;

  // Bridge model: answers after bridge_wait extra ACCESS cycles, garbage rdata when not ready
  always @(negedge clk) begin
    if (psel && enable) begin
      p_cfg_ready = !bridge_never && (acc_cnt == bridge_wait);
      acc_cnt     = acc_cnt + 1;
    end else begin
      p_cfg_ready = 1'b0;
      acc_cnt     = 0;
    end
    p_cfg_rdata = p_cfg_ready ? bridge_rdata : 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int d = 0; d < N; d++)
      if (m[(p + d) % N]) return (p + d) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit w, input logic [15:0] a, input logic [7:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = w;
    req_addr[16*i +: 16]  = a;
    req_wdata[8*i +: 8]   = d;
  endtask

  // Follows one transaction from grant to response; caller sets requests beforehand
  task automatic run_txn(input int g, input int wt, input bit never, input bit keep,
                         input logic [7:0] rd, output int glat);
    logic [N-1:0] oh;
    logic         w;
    logic [15:0]  a;
    logic [7:0]   d;
    int           n, en_cnt;
    oh = '0;
    oh[g] = 1'b1;
    w = req_write[g];
    a = req_addr[16*g +: 16];
    d = req_wdata[8*g +: 8];
    bridge_wait  = wt;
    bridge_never = never;
    bridge_rdata = rd;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    glat = n;
    check("grant", 32'(req_ready), 32'(oh));
    check("setup_phase", {psel, enable}, 2'b10);
    check("setup_bus", {write, addr, wdata}, {w, a, d});
    check("busy", busy, 1'b1);
    if (!keep) req_valid[g] = 1'b0;
    en_cnt = 0;
    n = 0;
    @(negedge clk);
    while (rsp_valid == '0 && n < 400) begin
      if (psel && enable && {write, addr, wdata} == {w, a, d}) en_cnt++;
      @(negedge clk);
      n++;
    end
    check("access_cycles", en_cnt, never ? TO : wt + 1);
    check("rsp_owner", 32'(rsp_valid), 32'(oh));
    check("rsp_rdata", rsp_rdata, (w || never) ? 8'h00 : rd);
    check("rsp_err", rsp_err, never);
    check("resp_phase", {psel, enable}, 2'b00);
    mptr = (g + 1) % N;
  endtask

  initial begin
    int glat, g, bad, saw0;
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, psel, enable,
                            write, addr, wdata}, '0);
    rst = 1'b0;

    // Single read from requester 0
    set_req(0, 1'b0, 16'h4010, 8'h00);
    run_txn(0, 0, 1'b0, 1'b0, 8'hA5, glat);
    check("grant_latency", glat, 0);

    // Write from requester 1 with three bridge wait cycles
    set_req(1, 1'b1, 16'h2005, 8'h3C);
    run_txn(1, 3, 1'b0, 1'b0, 8'h77, glat);

    // Requesters 0 and 1 held valid: strict alternation
    @(negedge clk);
    set_req(0, 1'b0, 16'h1000, 8'h11);
    set_req(1, 1'b1, 16'h3001, 8'h22);
    for (int t = 0; t < 6; t++) begin
      g = rr_pick(req_valid, mptr);
      check("alt_expected", g, t % 2);
      run_txn(g, t % 3, 1'b0, 1'b1, 8'($urandom), glat);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);

    // One-cycle pulse from requester 1 while busy must be ignored
    set_req(0, 1'b1, 16'h5002, 8'h9E);
    bridge_wait = 2; bridge_never = 1'b0;
    @(negedge clk);
    check("pulse_grant0", 32'(req_ready), 32'd1);
    req_valid[0] = 1'b0;
    set_req(1, 1'b0, 16'h0003, 8'h00);
    @(negedge clk);
    req_valid[1] = 1'b0;
    bad = 0; saw0 = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready[1] || rsp_valid[1]) bad = 1;
      if (rsp_valid[0]) saw0 = 1;
      @(negedge clk);
    end
    check("pulse_ignored", bad, 0);
    check("pulse_owner_done", saw0, 1);
    mptr = 1;

    // Reset while in ACCESS
    set_req(0, 1'b0, 16'h4100, 8'h00);
    set_req(2, 1'b0, 16'h4200, 8'h00);
    req_valid[0] = 1'b0;
    bridge_wait = 20;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("in_access", {psel, enable}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", {psel, enable, busy, rsp_valid, req_ready}, '0);
    rst = 1'b0;
    mptr = 0;
    set_req(0, 1'b0, 16'h0010, 8'h00);
    set_req(1, 1'b1, 16'h1010, 8'h5A);
    g = rr_pick(req_valid, mptr);
    check("ptr_after_reset", g, 0);
    run_txn(g, 1, 1'b0, 1'b0, 8'h3D, glat);
    run_txn(rr_pick(req_valid, mptr), 0, 1'b0, 1'b0, 8'h00, glat);

`ifdef HSST_APB_TIMEOUT_EN
    set_req(2, 1'b0, 16'h5000, 8'h00);
    run_txn(2, 0, 1'b1, 1'b0, 8'hEE, glat);
    set_req(2, 1'b0, 16'h5001, 8'h00);
    run_txn(rr_pick(req_valid, mptr), 1, 1'b0, 1'b0, 8'hC3, glat);
`endif

    // Randomized traffic against the RR model
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), 16'($urandom), 8'($urandom));
      if (req_valid == '0)
        set_req($urandom_range(0, N - 1), 1'($urandom), 16'($urandom), 8'($urandom));
      run_txn(rr_pick(req_valid, mptr), $urandom_range(0, 4), 1'b0, 1'b0, 8'($urandom), glat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
